// File: rtl/dds_cmd_decoder.sv
// Byte-stream command decoder for the DDS voice core. It parses command frames into
// per-voice frequency and envelope registers, and drops aborted or malformed frames.
module dds_cmd_decoder #(
    parameter int          NUM_VOICES     = 8,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  ENV_RESET      = 8'h00,
    localparam int         VW             = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int         CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      spi_nss_i,
    output logic [16*NUM_VOICES-1:0]  freq_bus_o,
    output logic [8*NUM_VOICES-1:0]   env_bus_o,
    output logic                      upd_valid_o,
    output logic [VW-1:0]             upd_voice_o,
    output logic                      upd_is_env_o,
    output logic                      frame_err_o,
    output logic [7:0]                led_o
);

    typedef enum logic [1:0] {S_IDLE, S_FREQ_HI, S_FREQ_LO, S_ENV} state_t;

    state_t                          state_q, state_d;
    logic [VW-1:0]                   voice_q, voice_d;
    logic [7:0]                      hi_q, hi_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [NUM_VOICES-1:0][15:0]     freq_q, freq_d;
    logic [NUM_VOICES-1:0][7:0]      env_q, env_d;
    logic                            upd_valid_q, upd_valid_d;
    logic [VW-1:0]                   upd_voice_q, upd_voice_d;
    logic                            upd_is_env_q, upd_is_env_d;
    logic                            frame_err_q, frame_err_d;
    logic [7:0]                      led_q, led_d;

    logic       accept, timeout, abort, cmd_ok;
    logic [7:0] cmd_m1;

    assign accept  = rx_valid_i & ~spi_nss_i;
    // The abort lands on the edge where the counter would reach TIMEOUT_CYCLES.
    assign timeout = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
    assign abort   = (state_q != S_IDLE) & (spi_nss_i | timeout);
    assign cmd_m1  = rx_data_i - 8'd1;
    assign cmd_ok  = (rx_data_i != 8'd0) && ({1'b0, rx_data_i} <= 9'(2 * NUM_VOICES));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            voice_q      <= '0;
            hi_q         <= '0;
            cnt_q        <= '0;
            freq_q       <= '0;
            env_q        <= {NUM_VOICES{ENV_RESET}};
            upd_valid_q  <= 1'b0;
            upd_voice_q  <= '0;
            upd_is_env_q <= 1'b0;
            frame_err_q  <= 1'b0;
            led_q        <= '0;
        end else begin
            voice_q      <= voice_d;
            hi_q         <= hi_d;
            cnt_q        <= cnt_d;
            freq_q       <= freq_d;
            env_q        <= env_d;
            upd_valid_q  <= upd_valid_d;
            upd_voice_q  <= upd_voice_d;
            upd_is_env_q <= upd_is_env_d;
            frame_err_q  <= frame_err_d;
            led_q        <= led_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        voice_d      = voice_q;
        hi_d         = hi_q;
        freq_d       = freq_q;
        env_d        = env_q;
        upd_valid_d  = 1'b0;
        upd_voice_d  = upd_voice_q;
        upd_is_env_d = upd_is_env_q;
        frame_err_d  = 1'b0;
        led_d        = led_q;

        if (state_q == S_IDLE || accept) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (abort) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end else if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_ok) begin
                        voice_d = VW'(cmd_m1 >> 1);
                        led_d   = rx_data_i;
                        state_d = cmd_m1[0] ? S_ENV : S_FREQ_HI;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_FREQ_HI: begin
                    hi_d    = rx_data_i;
                    state_d = S_FREQ_LO;
                end
                S_FREQ_LO: begin
                    freq_d[voice_q] = {hi_q, rx_data_i};
                    upd_valid_d     = 1'b1;
                    upd_voice_d     = voice_q;
                    upd_is_env_d    = 1'b0;
                    state_d         = S_IDLE;
                end
                S_ENV: begin
                    env_d[voice_q] = rx_data_i;
                    upd_valid_d    = 1'b1;
                    upd_voice_d    = voice_q;
                    upd_is_env_d   = 1'b1;
                    state_d        = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign freq_bus_o   = freq_q;
    assign env_bus_o    = env_q;
    assign upd_valid_o  = upd_valid_q;
    assign upd_voice_o  = upd_voice_q;
    assign upd_is_env_o = upd_is_env_q;
    assign frame_err_o  = frame_err_q;
    assign led_o        = led_q;

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// Scoreboard bench for dds_cmd_decoder: stimulus pushes expected update/error events,
// and a monitor pops and compares them whenever the DUT pulses upd_valid or frame_err.
module tb_dds_cmd_decoder;

    localparam int         NV   = 8;
    localparam int         TO   = 16;
    localparam logic [7:0] ENVR = 8'h5A;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 rx_valid = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic                 spi_nss = 1'b0;
    logic [16*NV-1:0]     freq_bus;
    logic [8*NV-1:0]      env_bus;
    logic                 upd_valid;
    logic [2:0]           upd_voice;
    logic                 upd_is_env;
    logic                 frame_err;
    logic [7:0]           led;

    dds_cmd_decoder #(
        .NUM_VOICES    (NV),
        .TIMEOUT_CYCLES(TO),
        .ENV_RESET     (ENVR)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .spi_nss_i   (spi_nss),
        .freq_bus_o  (freq_bus),
        .env_bus_o   (env_bus),
        .upd_valid_o (upd_valid),
        .upd_voice_o (upd_voice),
        .upd_is_env_o(upd_is_env),
        .frame_err_o (frame_err),
        .led_o       (led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_freq [NV];
    logic [7:0]  m_env  [NV];

    typedef struct {
        bit               is_err;
        int               voice;
        bit               is_env;
        logic [16*NV-1:0] freq;
        logic [8*NV-1:0]  env;
    } exp_t;

    exp_t q[$];

    function automatic logic [16*NV-1:0] pack_f();
        logic [16*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[16*i +: 16] = m_freq[i];
        return r;
    endfunction

    function automatic logic [8*NV-1:0] pack_e();
        logic [8*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[8*i +: 8] = m_env[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_freq[i] = 16'h0000;
            m_env[i]  = ENVR;
        end
    endtask

    task automatic push(input bit is_err, input int v, input bit is_env);
        exp_t e;
        e.is_err = is_err;
        e.voice  = v;
        e.is_env = is_env;
        e.freq   = pack_f();
        e.env    = pack_e();
        q.push_back(e);
    endtask

    task automatic exp_freq(input int v, input logic [15:0] val);
        m_freq[v] = val;
        push(1'b0, v, 1'b0);
    endtask

    task automatic exp_env(input int v, input logic [7:0] val);
        m_env[v] = val;
        push(1'b0, v, 1'b1);
    endtask

    task automatic exp_err();
        push(1'b1, 0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd_valid || frame_err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event upd_valid=%0b frame_err=%0b required none",
                             upd_valid, frame_err);
                end else begin
                    e = q.pop_front();
                    check("ev_frame_err", 128'(frame_err), 128'(e.is_err));
                    check("ev_upd_valid", 128'(upd_valid), 128'(!e.is_err));
                    if (!e.is_err) begin
                        check("ev_upd_voice", 128'(upd_voice), 128'(e.voice));
                        check("ev_upd_is_env", 128'(upd_is_env), 128'(e.is_env));
                    end
                    check("ev_freq_bus", freq_bus, e.freq);
                    check("ev_env_bus", 128'(env_bus), 128'(e.env));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        reset   = 1'b1;
        spi_nss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        check("rst_freq_bus", freq_bus, 128'h0);
        check("rst_env_bus", 128'(env_bus), 128'(pack_e()));
        check("rst_upd_valid", 128'(upd_valid), 128'h0);
        check("rst_upd_voice", 128'(upd_voice), 128'h0);
        check("rst_upd_is_env", 128'(upd_is_env), 128'h0);
        check("rst_frame_err", 128'(frame_err), 128'h0);
        check("rst_led", 128'(led), 128'h0);

        // Frequency write to voice 0
        exp_freq(0, 16'h1234);
        send(8'h01); send(8'h12); send(8'h34);
        idle(2);
        check("t1_freq_bus", freq_bus, pack_f());
        check("t1_led", 128'(led), 128'h01);

        // Envelope write to the last voice, back-to-back bytes
        exp_env(7, 8'hA5);
        send(8'h10); send(8'hA5);
        idle(2);
        check("t2_env_bus", 128'(env_bus), 128'(pack_e()));
        check("t2_led", 128'(led), 128'h10);

        // Unknown commands then a valid frequency frame
        exp_err(); send(8'h00);
        exp_err(); send(8'h11);
        idle(1);
        check("t3_led_hold", 128'(led), 128'h10);
        exp_freq(1, 16'hBEEF);
        send(8'h03); send(8'hBE); send(8'hEF);
        idle(2);
        check("t3_freq_bus", freq_bus, pack_f());

        // Chip-select abort mid-frame
        exp_freq(2, 16'h1357);
        send(8'h05); send(8'h13); send(8'h57);
        send(8'h05); send(8'hAA);
        exp_err();
        spi_nss = 1'b1;
        idle(1);
        spi_nss = 1'b0;
        exp_env(2, 8'h80);
        send(8'h06); send(8'h80);
        idle(2);
        check("t4_freq_bus", freq_bus, pack_f());
        check("t4_env_bus", 128'(env_bus), 128'(pack_e()));

        // Bytes while chip select is high are ignored, even in IDLE
        spi_nss = 1'b1;
        send(8'h03);
        spi_nss = 1'b0;
        exp_env(6, 8'h44);
        send(8'h0E); send(8'h44);
        idle(2);
        check("t5_env_bus", 128'(env_bus), 128'(pack_e()));
        check("t5_led", 128'(led), 128'h0E);

        // Timeout boundary: byte at gap TO-1 accepted, byte at gap TO dropped
        send(8'h01);
        idle(TO - 2);
        send(8'h55);
        exp_err();
        idle(TO - 1);
        send(8'h66);
        idle(2);
        check("t6_freq_bus", freq_bus, pack_f());
        check("t6_queue_drained", 128'(q.size()), 128'h0);
        exp_freq(3, 16'h0001);
        send(8'h07); send(8'h00); send(8'h01);
        idle(2);
        check("t6_recover_freq", freq_bus, pack_f());

        // Reset mid-frame
        send(8'h01); send(8'h12);
        reset = 1'b1;
        model_reset();
        #1;
        check("t7_async_freq", freq_bus, 128'h0);
        check("t7_async_env", 128'(env_bus), 128'(pack_e()));
        idle(2);
        reset = 1'b0;
        exp_err();
        send(8'h34);
        idle(3);
        check("t7_freq_bus", freq_bus, 128'h0);
        check("t7_env_bus", 128'(env_bus), 128'(pack_e()));
        check("t7_led", 128'(led), 128'h0);

        idle(4);
        check("queue_empty", 128'(q.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
